// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types; ramstate_t is the RAM handshake seen by the memory controller.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/latency_ram.sv
// Word-addressed main memory with a programmable per-access latency.
// A request must be held unchanged for LAT wait cycles before it reaches ACCESS.
module latency_ram
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Contents are defined as zero at time 0 and deliberately untouched by nRST.
  logic [31:0] mem_r [DEPTH] = '{default: 32'h0000_0000};

  logic        valid_r;
  logic [29:0] lat_addr_r;
  logic        lat_wen_r;
  logic [3:0]  cnt_r;

  logic [29:0]   word_s;
  logic [AW-1:0] idx_s;
  logic          req_s;
  logic          illegal_s;
  logic          match_s;
  logic [3:0]    eff_s;
  logic          unused_s;

  assign word_s    = ramaddr[31:2];
  assign idx_s     = word_s[AW-1:0];
  assign req_s     = ramREN | ramWEN;
  assign illegal_s = (ramREN & ramWEN) | ({2'b00, word_s} >= 32'(DEPTH));
  assign match_s   = valid_r & (word_s == lat_addr_r) & (ramWEN == lat_wen_r);
  assign eff_s     = match_s ? cnt_r : 4'd0;
  assign unused_s  = ^ramaddr[1:0];

  // Handshake state decode, highest priority first.
  always_comb begin
    ramstate = FREE;
    if (illegal_s) begin
      ramstate = ERROR;
    end else if (!req_s) begin
      ramstate = FREE;
    end else if (eff_s == 4'(LAT)) begin
      ramstate = ACCESS;
    end else begin
      ramstate = BUSY;
    end
  end

  // Read data is only driven during a read ACCESS so the bus idles at zero.
  always_comb begin
    ramload = 32'h0000_0000;
    if ((ramstate == ACCESS) && ramREN) begin
      ramload = mem_r[idx_s];
    end else begin
      ramload = 32'h0000_0000;
    end
  end

  // Latency tracking: any state other than BUSY clears the count, so requests never merge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_r    <= 1'b0;
      lat_addr_r <= 30'd0;
      lat_wen_r  <= 1'b0;
      cnt_r      <= 4'd0;
    end else begin
      case (ramstate)
        BUSY: begin
          valid_r    <= 1'b1;
          lat_addr_r <= word_s;
          lat_wen_r  <= ramWEN;
          cnt_r      <= eff_s + 4'd1;
        end
        ACCESS, ERROR, FREE: begin
          valid_r <= 1'b0;
          cnt_r   <= 4'd0;
        end
        default: begin
          valid_r <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Write commit; gated by nRST so a reset cycle can never land a write.
  always_ff @(posedge CLK) begin
    if (nRST && (ramstate == ACCESS) && ramWEN) begin
      mem_r[idx_s] <= ramstore;
    end
  end

endmodule
